// File: rtl/chimera_clu_iso_if.sv
// Isolation sequencer bus: cluster requests, per-port isolate/isolated handshake and status.
// Master is the requesting/isolator side, slave is the sequencer.
interface chimera_clu_iso_if #(
  parameter int unsigned NumClusters = 5,
  parameter int unsigned NumPorts    = 4
);
  logic [NumClusters-1:0]          iso_req_i;
  logic [NumClusters*NumPorts-1:0] port_isolate_o;
  logic [NumClusters*NumPorts-1:0] port_isolated_i;
  logic [NumClusters-1:0]          clu_clk_en_o;
  logic [NumClusters-1:0]          isolated_o;
  logic [NumClusters-1:0]          busy_o;
  logic [NumClusters-1:0]          timeout_o;
  logic [NumClusters-1:0]          timeout_clr_i;

  modport master (
    output iso_req_i, port_isolated_i, timeout_clr_i,
    input  port_isolate_o, clu_clk_en_o, isolated_o, busy_o, timeout_o
  );

  modport slave (
    input  iso_req_i, port_isolated_i, timeout_clr_i,
    output port_isolate_o, clu_clk_en_o, isolated_o, busy_o, timeout_o
  );
endinterface

// File: rtl/chimera_clu_iso_seq.sv
// Per-cluster isolation sequencer: isolate ports, wait for acks, gate clock; reverse on release.
// One Moore FSM, one saturating cycle counter and one sticky timeout flag per cluster.
//
//   state       | meaning
//   ST_RUN      | cluster running, ports open, clock on
//   ST_DRAIN    | ports asked to isolate, waiting for all acks
//   ST_ISOLATED | all ports isolated, cluster clock gated
//   ST_WAKE     | clock back on for WakeCycles, ports still isolated
//   ST_RELEASE  | ports de-isolated, waiting for all acks to drop
module chimera_clu_iso_seq #(
  parameter int unsigned NumClusters   = 5,
  parameter int unsigned NumPorts      = 4,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned WakeCycles    = 2,
  parameter int unsigned CntWidth      =
    $clog2(((TimeoutCycles > WakeCycles) ? TimeoutCycles : WakeCycles) + 1)
) (
  input logic              clk_i,
  input logic              rst_i,
  chimera_clu_iso_if.slave bus
);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_DRAIN,
    ST_ISOLATED,
    ST_WAKE,
    ST_RELEASE
  } state_e;

  localparam logic [CntWidth-1:0] CntMax   = '1;
  localparam logic [CntWidth-1:0] WakeLast = CntWidth'(WakeCycles - 1);
  localparam logic [CntWidth-1:0] TmoLast  =
    CntWidth'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam bit TmoEn = (TimeoutCycles > 0);

  state_e                state_q [NumClusters];
  state_e                state_d [NumClusters];
  logic   [CntWidth-1:0] cnt_q   [NumClusters];
  logic   [CntWidth-1:0] cnt_d   [NumClusters];
  logic [NumClusters-1:0] timeout_q, timeout_d;

  logic [NumClusters*NumPorts-1:0] port_iso;
  logic [NumClusters-1:0]          clk_en, isolated, busy;

  always_comb begin
    timeout_d = timeout_q;
    for (int c = 0; c < NumClusters; c++) begin
      state_d[c] = state_q[c];
      unique case (state_q[c])
        ST_RUN:      if (bus.iso_req_i[c]) state_d[c] = ST_DRAIN;
        // completion is checked before abort so a coincident drop still isolates
        ST_DRAIN: begin
          if (&bus.port_isolated_i[c*NumPorts +: NumPorts]) state_d[c] = ST_ISOLATED;
          else if (!bus.iso_req_i[c])                        state_d[c] = ST_RELEASE;
        end
        ST_ISOLATED: if (!bus.iso_req_i[c]) state_d[c] = ST_WAKE;
        ST_WAKE:     if (cnt_q[c] == WakeLast) state_d[c] = ST_RELEASE;
        ST_RELEASE:  if (~|bus.port_isolated_i[c*NumPorts +: NumPorts]) state_d[c] = ST_RUN;
        default:     state_d[c] = ST_RUN;
      endcase

      cnt_d[c] = cnt_q[c];
      if (state_d[c] != state_q[c]) begin
        cnt_d[c] = '0;
      end else if ((state_q[c] inside {ST_DRAIN, ST_WAKE, ST_RELEASE}) &&
                   (cnt_q[c] != CntMax)) begin
        cnt_d[c] = cnt_q[c] + 1'b1;
      end

      // expiry lands on the same edge the counter reaches TimeoutCycles; set beats clear
      if (bus.timeout_clr_i[c]) timeout_d[c] = 1'b0;
      if (TmoEn && (state_q[c] inside {ST_DRAIN, ST_RELEASE}) &&
          (state_d[c] == state_q[c]) && (cnt_q[c] == TmoLast)) begin
        timeout_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < NumClusters; c++) begin
        state_q[c] <= ST_RUN;
        cnt_q[c]   <= '0;
      end
      timeout_q <= '0;
    end else begin
      for (int c = 0; c < NumClusters; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    port_iso = '0;
    clk_en   = '1;
    isolated = '0;
    busy     = '0;
    for (int c = 0; c < NumClusters; c++) begin
      port_iso[c*NumPorts +: NumPorts] =
        {NumPorts{state_q[c] inside {ST_DRAIN, ST_ISOLATED, ST_WAKE}}};
      clk_en[c]   = (state_q[c] != ST_ISOLATED);
      isolated[c] = (state_q[c] == ST_ISOLATED);
      busy[c]     = (state_q[c] inside {ST_DRAIN, ST_WAKE, ST_RELEASE});
    end
  end

  assign bus.port_isolate_o = port_iso;
  assign bus.clu_clk_en_o   = clk_en;
  assign bus.isolated_o     = isolated;
  assign bus.busy_o         = busy;
  assign bus.timeout_o      = timeout_q;

endmodule

// File: tb/tb_chimera_clu_iso_seq.sv
// Testbench for chimera_clu_iso_seq: directed scenarios plus randomized run vs a phase-level model.
module tb_chimera_clu_iso_seq;
  localparam int unsigned NC = 2;
  localparam int unsigned NP = 4;
  localparam int unsigned TC = 8;
  localparam int unsigned WC = 2;

  localparam int P_RUN   = 0;
  localparam int P_DRAIN = 1;
  localparam int P_SAFE  = 2;
  localparam int P_WAKE  = 3;
  localparam int P_REL   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  chimera_clu_iso_if #(.NumClusters(NC), .NumPorts(NP)) bus ();

  chimera_clu_iso_seq #(
    .NumClusters  (NC),
    .NumPorts     (NP),
    .TimeoutCycles(TC),
    .WakeCycles   (WC)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: phase per cluster, cycles spent in that phase, sticky flag
  int ph   [NC];
  int age  [NC];
  bit flag [NC];

  task automatic model_step();
    logic [NP-1:0] ports;
    int nxt;
    bit req, expire;
    for (int c = 0; c < NC; c++) begin
      if (rst) begin
        ph[c] = P_RUN; age[c] = 0; flag[c] = 1'b0;
      end else begin
        ports = bus.port_isolated_i[c*NP +: NP];
        req   = bus.iso_req_i[c];
        nxt   = ph[c];
        case (ph[c])
          P_RUN:   if (req) nxt = P_DRAIN;
          P_DRAIN: if (ports == {NP{1'b1}}) nxt = P_SAFE; else if (!req) nxt = P_REL;
          P_SAFE:  if (!req) nxt = P_WAKE;
          P_WAKE:  if (age[c] + 1 >= WC) nxt = P_REL;
          P_REL:   if (ports == '0) nxt = P_RUN;
          default: nxt = P_RUN;
        endcase
        // the TC-th cycle spent waiting in DRAIN/RELEASE without leaving raises the flag
        expire = (ph[c] == P_DRAIN || ph[c] == P_REL) && (nxt == ph[c]) && (age[c] + 1 == TC);
        if (expire) flag[c] = 1'b1;
        else if (bus.timeout_clr_i[c]) flag[c] = 1'b0;
        age[c] = (nxt == ph[c]) ? age[c] + 1 : 0;
        ph[c]  = nxt;
      end
    end
  endtask

  function automatic logic [15:0] model_out();
    logic [7:0] pi;
    logic [1:0] ce, is, bz, to;
    pi = '0; ce = '1; is = '0; bz = '0; to = '0;
    for (int c = 0; c < NC; c++) begin
      pi[c*NP +: NP] = (ph[c] == P_DRAIN || ph[c] == P_SAFE || ph[c] == P_WAKE) ? 4'hF : 4'h0;
      ce[c] = (ph[c] != P_SAFE);
      is[c] = (ph[c] == P_SAFE);
      bz[c] = (ph[c] == P_DRAIN || ph[c] == P_WAKE || ph[c] == P_REL);
      to[c] = flag[c];
    end
    return {pi, ce, is, bz, to};
  endfunction

  function automatic logic [15:0] snap();
    return {bus.port_isolate_o, bus.clu_clk_en_o, bus.isolated_o, bus.busy_o, bus.timeout_o};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.iso_req_i       = '0;
    bus.port_isolated_i = '0;
    bus.timeout_clr_i   = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    do_reset();
    exp = {8'h00, 2'b11, 2'b00, 2'b00, 2'b00};
    n_cmp++;
    if (snap() !== exp) begin
      n_err++; $display("FAIL reset_vals: got %h want %h", snap(), exp);
    end
    tick();
    n_cmp++;
    if (snap() !== exp) begin
      n_err++; $display("FAIL reset_idle: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_isolate();
    logic [15:0] exp;
    do_reset();
    bus.iso_req_i = 2'b01;
    exp = {8'h0F, 2'b11, 2'b00, 2'b01, 2'b00};
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++;
      if (snap() !== exp) begin
        n_err++; $display("FAIL drain_c%0d: got %h want %h", i, snap(), exp);
      end
    end
    bus.port_isolated_i = 8'h0F;
    tick();
    exp = {8'h0F, 2'b10, 2'b01, 2'b00, 2'b00};
    n_cmp++;
    if (snap() !== exp) begin
      n_err++; $display("FAIL isolated_c4: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_release();
    logic [15:0] exp;
    bus.iso_req_i = 2'b00;
    exp = {8'h0F, 2'b11, 2'b00, 2'b01, 2'b00};
    for (int i = 1; i <= 2; i++) begin
      tick();
      n_cmp++;
      if (snap() !== exp) begin
        n_err++; $display("FAIL wake_c%0d: got %h want %h", i, snap(), exp);
      end
    end
    tick();
    exp = {8'h00, 2'b11, 2'b00, 2'b01, 2'b00};
    n_cmp++;
    if (snap() !== exp) begin
      n_err++; $display("FAIL release_c3: got %h want %h", snap(), exp);
    end
    bus.port_isolated_i = 8'h00;
    tick();
    exp = {8'h00, 2'b11, 2'b00, 2'b00, 2'b00};
    n_cmp++;
    if (snap() !== exp) begin
      n_err++; $display("FAIL run_c4: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_timeout();
    logic [15:0] exp;
    do_reset();
    bus.iso_req_i       = 2'b01;
    bus.port_isolated_i = 8'h07;
    exp = {8'h0F, 2'b11, 2'b00, 2'b01, 2'b00};
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_cmp++;
      if (snap() !== exp) begin
        n_err++; $display("FAIL drain_no_tmo_%0d: got %h want %h", i, snap(), exp);
      end
    end
    exp = {8'h0F, 2'b11, 2'b00, 2'b01, 2'b01};
    for (int i = 9; i <= 10; i++) begin
      tick();
      n_cmp++;
      if (snap() !== exp) begin
        n_err++; $display("FAIL drain_tmo_%0d: got %h want %h", i, snap(), exp);
      end
    end
    bus.port_isolated_i = 8'h0F;
    tick();
    tick();
    tick();
    exp = {8'h0F, 2'b10, 2'b01, 2'b00, 2'b01};
    n_cmp++;
    if (snap() !== exp) begin
      n_err++; $display("FAIL tmo_sticky: got %h want %h", snap(), exp);
    end
    bus.timeout_clr_i = 2'b01;
    tick();
    bus.timeout_clr_i = 2'b00;
    exp = {8'h0F, 2'b10, 2'b01, 2'b00, 2'b00};
    n_cmp++;
    if (snap() !== exp) begin
      n_err++; $display("FAIL tmo_clr: got %h want %h", snap(), exp);
    end
    // release with acks stuck high so RELEASE times out; clear lands on the setting cycle
    bus.iso_req_i = 2'b00;
    tick();
    tick();
    tick();
    for (int i = 2; i <= 8; i++) tick();
    exp = {8'h00, 2'b11, 2'b00, 2'b01, 2'b00};
    n_cmp++;
    if (snap() !== exp) begin
      n_err++; $display("FAIL rel8_no_tmo: got %h want %h", snap(), exp);
    end
    bus.timeout_clr_i = 2'b01;
    tick();
    bus.timeout_clr_i = 2'b00;
    exp = {8'h00, 2'b11, 2'b00, 2'b01, 2'b01};
    n_cmp++;
    if (snap() !== exp) begin
      n_err++; $display("FAIL set_beats_clr: got %h want %h", snap(), exp);
    end
    bus.port_isolated_i = 8'h00;
    tick();
    exp = {8'h00, 2'b11, 2'b00, 2'b00, 2'b01};
    n_cmp++;
    if (snap() !== exp) begin
      n_err++; $display("FAIL rel_to_run_tmo: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_abort();
    logic [15:0] exp;
    do_reset();
    bus.iso_req_i       = 2'b01;
    bus.port_isolated_i = 8'h03;
    tick();
    tick();
    tick();
    bus.iso_req_i = 2'b00;
    tick();
    exp = {8'h00, 2'b11, 2'b00, 2'b01, 2'b00};
    n_cmp++;
    if (snap() !== exp) begin
      n_err++; $display("FAIL abort_rel: got %h want %h", snap(), exp);
    end
    tick();
    n_cmp++;
    if (snap() !== exp) begin
      n_err++; $display("FAIL abort_hold: got %h want %h", snap(), exp);
    end
    bus.port_isolated_i = 8'h00;
    tick();
    exp = {8'h00, 2'b11, 2'b00, 2'b00, 2'b00};
    n_cmp++;
    if (snap() !== exp) begin
      n_err++; $display("FAIL abort_run: got %h want %h", snap(), exp);
    end
    bus.iso_req_i = 2'b01;
    tick();
    bus.port_isolated_i = 8'h0F;
    bus.iso_req_i       = 2'b00;
    tick();
    exp = {8'h0F, 2'b10, 2'b01, 2'b00, 2'b00};
    n_cmp++;
    if (snap() !== exp) begin
      n_err++; $display("FAIL complete_beats_abort: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp;
    do_reset();
    bus.iso_req_i       = 2'b10;
    bus.port_isolated_i = 8'hF0;
    tick();
    tick();
    exp = {8'hF0, 2'b01, 2'b10, 2'b00, 2'b00};
    n_cmp++;
    if (snap() !== exp) begin
      n_err++; $display("FAIL c1_isolated: got %h want %h", snap(), exp);
    end
    bus.iso_req_i = 2'b01;
    tick();
    exp = {8'hFF, 2'b11, 2'b00, 2'b11, 2'b00};
    n_cmp++;
    if (snap() !== exp) begin
      n_err++; $display("FAIL wake_and_drain: got %h want %h", snap(), exp);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.iso_req_i       = 2'b00;
    bus.port_isolated_i = 8'h00;
    exp = {8'h00, 2'b11, 2'b00, 2'b00, 2'b00};
    n_cmp++;
    if (snap() !== exp) begin
      n_err++; $display("FAIL mid_reset: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_stagger();
    logic [15:0] exp;
    do_reset();
    bus.iso_req_i = 2'b11;
    tick();
    exp = {8'hFF, 2'b11, 2'b00, 2'b11, 2'b00};
    n_cmp++;
    if (snap() !== exp) begin
      n_err++; $display("FAIL both_drain: got %h want %h", snap(), exp);
    end
    tick();
    bus.port_isolated_i = 8'h0F;
    exp = {8'hFF, 2'b10, 2'b01, 2'b10, 2'b00};
    for (int i = 3; i <= 5; i++) begin
      tick();
      n_cmp++;
      if (snap() !== exp) begin
        n_err++; $display("FAIL stagger_c%0d: got %h want %h", i, snap(), exp);
      end
    end
    bus.port_isolated_i = 8'hFF;
    tick();
    exp = {8'hFF, 2'b00, 2'b11, 2'b00, 2'b00};
    n_cmp++;
    if (snap() !== exp) begin
      n_err++; $display("FAIL stagger_c6: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_random();
    logic [NP-1:0] v;
    logic [15:0] exp;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 11) == 0) bus.iso_req_i[c] = ~bus.iso_req_i[c];
        if ($urandom_range(0, 4) == 0) begin
          case ($urandom_range(0, 3))
            0:       v = '0;
            1:       v = '1;
            default: v = NP'($urandom);
          endcase
          bus.port_isolated_i[c*NP +: NP] = v;
        end
        bus.timeout_clr_i[c] = ($urandom_range(0, 15) == 0);
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
      exp = model_out();
      n_cmp++;
      if (snap() !== exp) begin
        n_err++; $display("FAIL random_%0d: got %h want %h", n, snap(), exp);
      end
    end
    rst = 1'b0;
    bus.timeout_clr_i = '0;
  endtask

  initial begin
    bus.iso_req_i       = '0;
    bus.port_isolated_i = '0;
    bus.timeout_clr_i   = '0;
    test_reset();
    test_isolate();
    test_release();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_stagger();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/chimera_clu_iso_seq.md
Name: chimera_clu_iso_seq

Overview:
- Per-cluster isolation sequencer for the external-cluster domain. It replaces the static per-port isolate fan-out with a handshaked FSM per cluster.
- On request, the FSM isolates all AXI ports of the cluster, waits for every port to acknowledge, then gates the cluster clock.
- On release, it restores the clock first, then de-isolates the ports.
- Adds drain timeout detection and busy status; generalised over cluster count and ports per cluster.

Parameters:
- NumClusters, 5, number of independent clusters (one FSM each).
- NumPorts, 4, isolatable AXI ports per cluster (narrow in, 2x narrow out, wide out).
- TimeoutCycles, 1024, max cycles in DRAIN or RELEASE before timeout flags; 0 disables timeout.
- WakeCycles, 2, cycles the clock is re-enabled with ports still isolated before release (>=1).
- CntWidth, $clog2(max(TimeoutCycles,WakeCycles)+1), derived; do not override.

Ports:
- clk_i  in  1  SoC clock.
- rst_i  in  1  synchronous, active-high reset.
- iso_req_i  in  NumClusters  level request; 1 = isolate cluster c.
- port_isolate_o  out  NumClusters*NumPorts  to per-port isolator isolate_i; bit c*NumPorts+p.
- port_isolated_i  in  NumClusters*NumPorts  per-port isolated status, same layout.
- clu_clk_en_o  out  NumClusters  cluster clock enable.
- isolated_o  out  NumClusters  cluster fully isolated and clock gated.
- busy_o  out  NumClusters  FSM in transition (DRAIN, WAKE, RELEASE).
- timeout_o  out  NumClusters  sticky timeout flag.
- timeout_clr_i  in  NumClusters  clears timeout_o[c].

Behaviour:
- One Moore FSM plus one CntWidth counter per cluster; all outputs decode from registered state only.
- Reset, synchronous on rst_i=1: state RUN, counter 0, port_isolate_o 0, clu_clk_en_o all 1, isolated_o 0, busy_o 0, timeout_o 0. Reset asserted mid-sequence returns to RUN the next edge regardless of port status.
- Per-state outputs (port_isolate, clk_en, isolated, busy):
  - RUN: 0, 1, 0, 0.
  - DRAIN: 1, 1, 0, 1.
  - ISOLATED: 1, 0, 1, 0.
  - WAKE: 1, 1, 0, 1.
  - RELEASE: 0, 1, 0, 1.
- port_isolate_o drives all NumPorts bits of a cluster identically.
- Transitions:
  - RUN: iso_req_i=1 -> DRAIN. Latency is 1 cycle from request to port_isolate_o high.
  - DRAIN: all NumPorts port_isolated_i bits of the cluster = 1 -> ISOLATED. Otherwise, iso_req_i=0 -> RELEASE (abort). Completion has priority over abort.
  - ISOLATED: iso_req_i=0 -> WAKE.
  - WAKE: stays exactly WakeCycles cycles, ignores iso_req_i, then -> RELEASE.
  - RELEASE: all port bits = 0 -> RUN. Then, if iso_req_i=1, re-enters DRAIN on the following cycle. No skip from RELEASE directly to DRAIN.
- Counter:
  - Cleared on every state entry; increments each cycle in DRAIN, WAKE and RELEASE.
  - Saturates at its maximum; never wraps.
- Timeout:
  - In DRAIN or RELEASE, with TimeoutCycles>0: when the counter reaches TimeoutCycles without the exit condition, set timeout_o[c] in that same cycle.
  - The FSM stays in its state; no forced exit, and isolation keeps being requested.
  - If completion and expiry occur in the same cycle, completion wins and no flag is set.
- timeout_clr_i:
  - Clears the flag next cycle.
  - If set and clear coincide, set wins.
- Clusters are fully independent; no shared arbitration.
- Port bits of the cluster ignored in RUN and ISOLATED. A drop in ISOLATED is not re-checked; the clock stays gated.

Test Plan:
(NumClusters=2, NumPorts=4, TimeoutCycles=8, WakeCycles=2)
1. Reset, then iso_req_i=01 at cycle 0 -> port_isolate_o=0x0F at cycle 1, busy_o=01. port_isolated_i[3:0]=0xF at cycle 3 -> isolated_o=01 and clu_clk_en_o=10 at cycle 4; cluster 1 outputs unchanged throughout.
2. From ISOLATED, iso_req_i=00 at cycle 0 -> clu_clk_en_o[0]=1 at cycle 1, port_isolate_o stays 0x0F through cycle 2, then 0x00 at cycle 3. port_isolated_i=0 at cycle 3 -> RUN and busy_o[0]=0 at cycle 4.
3. DRAIN with port_isolated_i[3:0]=0x7 held -> timeout_o[0]=1 after 8 DRAIN cycles, state remains DRAIN. Ports then go 0xF -> ISOLATED; timeout_o stays 1 until timeout_clr_i[0] is pulsed. Pulse clr on the cycle of a new set -> flag stays 1.
4. Abort: iso_req_i[0] drops on the 3rd DRAIN cycle with ports 0x3 -> RELEASE next cycle, port_isolate_o[3:0]=0. Ports 0x0 -> RUN. Same-cycle completion and drop -> ISOLATED.
5. rst_i pulsed while cluster 1 is in WAKE and cluster 0 is in DRAIN -> next cycle all outputs equal reset values.
6. Both clusters requested at cycle 0 with staggered acks at cycles 2 and 5 -> isolated_o=01 at cycle 3 and 11 at cycle 6.
